// File: rtl/fir_mac_scheduler.sv
// Time-multiplexed FIR controller: one shared multiplier and accumulator stepped across all taps.
// Owns the delay line and the coefficient RAM, and gives results valid/ready flow control.
module fir_mac_scheduler #(
   parameter int unsigned TAPS      = 9,
   parameter int unsigned DW        = 16,
   parameter int unsigned ACC_W     = 36,
   parameter int unsigned OUT_SHIFT = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out_data,
   input  logic                 coef_we,
   input  logic [3:0]           coef_addr,
   input  logic signed [DW-1:0] coef_data,
   output logic                 coef_err,
   output logic                 busy
);

   localparam int unsigned AW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int unsigned IW = $clog2(TAPS + 1);
   localparam int unsigned PW = 2 * DW;

   typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

   state_e                  state_q, state_d;
   logic signed [DW-1:0]    d_q [TAPS];
   logic signed [DW-1:0]    d_d [TAPS];
   logic signed [DW-1:0]    c_q [TAPS];
   logic signed [DW-1:0]    c_d [TAPS];
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic signed [DW-1:0]    out_data_q, out_data_d;
   logic                    coef_err_q, coef_err_d;

   logic                    coef_ok;
   logic                    mac_step;
   logic [AW-1:0]           idx_sel;
   logic signed [PW-1:0]    mul_a, mul_b, prod;
   logic signed [ACC_W-1:0] shifted;
   logic [ACC_W-DW:0]       shifted_hi;
   logic signed [DW-1:0]    sat_val;

   function automatic logic signed [DW-1:0] def_coef(input int unsigned i);
      case (i)
         0, 8:    return DW'(32'h04F6);
         1, 7:    return DW'(32'h0AE4);
         2, 6:    return DW'(32'h1089);
         3, 5:    return DW'(32'h1496);
         4:       return DW'(32'h160F);
         default: return '0;
      endcase
   endfunction

   // idx_q reaches TAPS on the cycle that registers the result; keep the read index in range.
   assign mac_step = (idx_q < IW'(TAPS));
   assign idx_sel  = mac_step ? idx_q[AW-1:0] : '0;
   assign mul_a    = PW'(d_q[idx_sel]);
   assign mul_b    = PW'(c_q[idx_sel]);
   assign prod     = mul_a * mul_b;

   // Floor shift, then clamp whenever the bits above the output sign are not a pure sign extension.
   always_comb begin
      shifted    = acc_q >>> OUT_SHIFT;
      shifted_hi = shifted[ACC_W-1:DW-1];
      if (shifted_hi == '0 || shifted_hi == '1) begin
         sat_val = shifted[DW-1:0];
      end else if (shifted[ACC_W-1]) begin
         sat_val = {1'b1, {(DW-1){1'b0}}};
      end else begin
         sat_val = {1'b0, {(DW-1){1'b1}}};
      end
   end

   always_comb begin
      state_d    = state_q;
      d_d        = d_q;
      c_d        = c_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      out_data_d = out_data_q;

      coef_ok    = coef_we && (state_q == StIdle) && (32'(coef_addr) < TAPS);
      coef_err_d = coef_we && !coef_ok;
      if (coef_ok) begin
         c_d[coef_addr[AW-1:0]] = coef_data;
      end

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               d_d[0] = in_data;
               for (int k = 1; k < int'(TAPS); k++) begin
                  d_d[k] = d_q[k-1];
               end
               acc_d   = '0;
               idx_d   = '0;
               state_d = StMac;
            end
         end
         StMac: begin
            if (mac_step) begin
               acc_d = acc_q + ACC_W'(prod);
               idx_d = idx_q + 1'b1;
            end else begin
               out_data_d = sat_val;
               state_d    = StOut;
            end
         end
         StOut: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         acc_q      <= '0;
         idx_q      <= '0;
         out_data_q <= '0;
         coef_err_q <= 1'b0;
         for (int k = 0; k < int'(TAPS); k++) begin
            d_q[k] <= '0;
            c_q[k] <= def_coef(k);
         end
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         out_data_q <= out_data_d;
         coef_err_q <= coef_err_d;
         d_q        <= d_d;
         c_q        <= c_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StOut);
   assign busy      = (state_q != StIdle);
   assign out_data  = out_data_q;
   assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench for fir_mac_scheduler: transaction-level reference model compared every
// cycle, plus hand-computed impulse/step/saturation values.
module tb_fir_mac_scheduler;

   localparam int TAPS = 9;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [15:0] in_data = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic signed [15:0] out_data;
   logic               coef_we = 1'b0;
   logic [3:0]         coef_addr = '0;
   logic signed [15:0] coef_data = '0;
   logic               coef_err;
   logic               busy;

   int checks = 0;
   int errors = 0;
   bit rmode = 1'b0;

   fir_mac_scheduler dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .coef_err  (coef_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // Reference model: a phase (idle / computing / presenting) plus a cycle count from the accept.
   int m_ph;
   int m_cnt;
   int m_out;
   int m_res;
   bit m_err;
   int hist [TAPS];
   int cf [TAPS];
   int m_log[$];
   int d_log[$];

   function automatic int default_coef(input int i);
      int tbl [TAPS] = '{1270, 2788, 4233, 5270, 5647, 5270, 4233, 2788, 1270};
      return tbl[i];
   endfunction

   function automatic int filt();
      longint s = 0;
      for (int k = 0; k < TAPS; k++) s += longint'(hist[k]) * longint'(cf[k]);
      s = s >>> 14;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return int'(s);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = 0; m_cnt = 0; m_out = 0; m_err = 1'b0;
         for (int k = 0; k < TAPS; k++) begin
            hist[k] = 0;
            cf[k]   = default_coef(k);
         end
      end else begin
         bit err_n;
         err_n = coef_we && !(m_ph == 0 && int'(coef_addr) < TAPS);
         case (m_ph)
            0: begin
               if (coef_we && int'(coef_addr) < TAPS) cf[coef_addr] = int'(coef_data);
               if (in_valid) begin
                  for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
                  hist[0] = int'(in_data);
                  m_res   = filt();
                  m_cnt   = TAPS + 1;
                  m_ph    = 1;
               end
            end
            1: begin
               m_cnt--;
               if (m_cnt == 0) begin
                  m_ph  = 2;
                  m_out = m_res;
               end
            end
            default: begin
               if (out_ready) begin
                  m_log.push_back(m_out);
                  m_ph = 0;
               end
            end
         endcase
         m_err = err_n;
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("in_ready", int'(in_ready), int'(m_ph == 0));
      chk("out_valid", int'(out_valid), int'(m_ph == 2));
      chk("busy", int'(busy), int'(m_ph != 0));
      chk("coef_err", int'(coef_err), int'(m_err));
      if (m_ph == 2 || !rst_n) chk("out_data", int'(out_data), m_out);
      if (rst_n && out_valid && out_ready) d_log.push_back(int'(out_data));
   end

   always @(posedge clk) begin
      if (rmode) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic send(input logic [15:0] v);
      bit got = 1'b0;
      in_valid = 1'b1;
      in_data  = v;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!got) chk("send_timeout", 0, 1);
   endtask

   task automatic coef_write(input logic [3:0] a, input logic [15:0] v);
      coef_we   = 1'b1;
      coef_addr = a;
      coef_data = v;
      @(posedge clk);
      #1;
      coef_we = 1'b0;
   endtask

   task automatic wait_outputs(input int n);
      for (int i = 0; i < 1000 && m_log.size() < n; i++) begin
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      chk("model_out_count", m_log.size(), n);
      chk("dut_out_count", d_log.size(), n);
   endtask

   task automatic clear_logs();
      m_log.delete();
      d_log.delete();
   endtask

   task automatic pin(input string name, input int idx, input int exp);
      chk({name, "_model"}, (idx < m_log.size()) ? m_log[idx] : 99999, exp);
      chk({name, "_dut"}, (idx < d_log.size()) ? d_log[idx] : 99999, exp);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_coef_err", int'(coef_err), 0);
      chk("rst_out_data", int'(out_data), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_logs();
   endtask

   initial begin
      #2 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("init_in_ready", int'(in_ready), 1);
      chk("init_out_valid", int'(out_valid), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Reset in the middle of a MAC run abandons the result.
      send(16'h1234);
      repeat (3) begin @(posedge clk); #1; end
      do_reset();
      repeat (TAPS + 4) begin @(posedge clk); #1; end
      chk("abandoned_no_output", d_log.size(), 0);

      // Impulse response with default coefficients.
      out_ready = 1'b1;
      send(16'h7FFF);
      for (int i = 0; i < 8; i++) send(16'h0000);
      wait_outputs(9);
      pin("imp1", 0, 32'h09EB);
      pin("imp2", 1, 32'h15C7);
      pin("imp3", 2, 32'h2111);
      pin("imp5", 4, 32'h2C1D);
      pin("imp9", 8, 32'h09EB);
      clear_logs();

      // DC step.
      for (int i = 0; i < 9; i++) send(16'h1000);
      wait_outputs(9);
      pin("dc9", 8, 32'h2000);

      // Saturation, positive then negative.
      do_reset();
      for (int a = 0; a < TAPS; a++) coef_write(4'(a), 16'h7FFF);
      for (int i = 0; i < 9; i++) send(16'h7FFF);
      wait_outputs(9);
      pin("satpos9", 8, 32767);
      do_reset();
      for (int a = 0; a < TAPS; a++) coef_write(4'(a), 16'h7FFF);
      for (int i = 0; i < 9; i++) send(16'h8000);
      wait_outputs(9);
      pin("satneg9", 8, -32768);

      // Coefficient protocol.
      do_reset();
      coef_write(4'd4, 16'h0000);
      @(negedge clk);
      chk("coef_ok_no_err", int'(coef_err), 0);
      @(posedge clk); #1;
      send(16'h7FFF);
      coef_write(4'd2, 16'h1111);
      @(negedge clk);
      chk("coef_err_mac", int'(coef_err), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("coef_err_mac_clear", int'(coef_err), 0);
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) send(16'h0000);
      wait_outputs(9);
      pin("zero5", 4, 0);
      pin("unchanged3", 2, 32'h2111);
      clear_logs();
      coef_write(4'd9, 16'h1111);
      @(negedge clk);
      chk("coef_err_addr", int'(coef_err), 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("coef_err_addr_clear", int'(coef_err), 0);
      @(posedge clk); #1;

      // Backpressure: result held, a waiting sample not consumed until after the handshake.
      out_ready = 1'b0;
      send(16'h4000);
      in_valid = 1'b1;
      in_data  = 16'h2222;
      repeat (TAPS + 6) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(16'h2222);
      wait_outputs(2);
      clear_logs();

      // Randomized traffic with random backpressure and coefficient writes.
      rmode = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 2) != 0);
         in_data   = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'($urandom_range(0, 4095));
         coef_we   = ($urandom_range(0, 7) == 0);
         coef_addr = 4'($urandom_range(0, 15));
         coef_data = 16'($urandom);
         @(posedge clk);
         #1;
      end
      rmode     = 1'b0;
      in_valid  = 1'b0;
      coef_we   = 1'b0;
      out_ready = 1'b1;
      repeat (TAPS + 6) begin @(posedge clk); #1; end
      chk("rand_out_count", d_log.size(), m_log.size());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
